// File: rtl/coord_ascii_tx_if.sv
// rtl/coord_ascii_tx_if.sv - coordinate capture inputs and byte stream handshake for coord_ascii_tx
interface coord_ascii_tx_if;
  logic [7:0] x;
  logic [7:0] y;
  logic       sample;
  logic       busy;
  logic       dropped;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output x, y, sample, tx_ready,
    input  busy, dropped, tx_data, tx_valid
  );

  modport slave (
    input  x, y, sample, tx_ready,
    output busy, dropped, tx_data, tx_valid
  );
endinterface

// File: rtl/coord_ascii_tx.sv
// rtl/coord_ascii_tx.sv - captures a signed (x,y) pair and streams it as an ASCII decimal line
module coord_ascii_tx #(
  parameter logic [7:0] SEP    = 8'h2C,
  parameter bit         EOL_CR = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  coord_ascii_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, SEND} state_e;

  state_e      state_q, state_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [3:0]  ptr_q, ptr_d, len_q, len_d;
  logic [7:0]  msg_q [16];
  logic [7:0]  msg_d [16];
  logic [3:0]  wr_idx;
  logic [34:0] fx, fy;
  logic        load;

  // Returns {byte count, bytes packed LSB-first} for one signed field.
  function automatic logic [34:0] fmt_field(input logic [7:0] v);
    logic [8:0]       mag, rem;
    logic [3:0]       h, t, o;
    logic [3:0][7:0]  f;
    logic [2:0]       n;
    mag = v[7] ? 9'(9'd256 - {1'b0, v}) : {1'b0, v};
    if (mag >= 9'd200) begin
      h = 4'd2; rem = mag - 9'd200;
    end else if (mag >= 9'd100) begin
      h = 4'd1; rem = mag - 9'd100;
    end else begin
      h = 4'd0; rem = mag;
    end
    t = 4'(rem / 9'd10);
    o = 4'(rem % 9'd10);
    f = '0;
    n = '0;
    if (v[7]) begin
      f[n[1:0]] = 8'h2D; n = n + 3'd1;
    end
    if (h != 4'd0) begin
      f[n[1:0]] = {4'h3, h}; n = n + 3'd1;
    end
    if (h != 4'd0 || t != 4'd0) begin
      f[n[1:0]] = {4'h3, t}; n = n + 3'd1;
    end
    f[n[1:0]] = {4'h3, o};
    n = n + 3'd1;
    return {n, f};
  endfunction

  always_comb begin
    fx = fmt_field(x_q);
    fy = fmt_field(y_q);
    wr_idx = '0;
    for (int i = 0; i < 16; i++) msg_d[i] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < fx[34:32]) begin
        msg_d[wr_idx] = fx[8*k +: 8];
        wr_idx = wr_idx + 4'd1;
      end
    end
    msg_d[wr_idx] = SEP;
    wr_idx = wr_idx + 4'd1;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < fy[34:32]) begin
        msg_d[wr_idx] = fy[8*k +: 8];
        wr_idx = wr_idx + 4'd1;
      end
    end
    if (EOL_CR) begin
      msg_d[wr_idx] = 8'h0D;
      wr_idx = wr_idx + 4'd1;
    end
    msg_d[wr_idx] = 8'h0A;
    len_d = wr_idx + 4'd1;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sample) begin
          x_d     = bus.x;
          y_d     = bus.y;
          state_d = CONV;
        end
      end
      CONV: begin
        load    = 1'b1;
        ptr_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        // The pointer parks on the last byte so tx_data keeps its final value while idle.
        if (bus.tx_ready) begin
          if (ptr_q == len_q - 4'd1) state_d = IDLE;
          else                       ptr_d   = ptr_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      for (int i = 0; i < 16; i++) msg_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ptr_q   <= ptr_d;
      if (load) begin
        len_q <= len_d;
        for (int i = 0; i < 16; i++) msg_q[i] <= msg_d[i];
      end
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.tx_valid = (state_q == SEND);
  assign bus.tx_data  = msg_q[ptr_q];
  assign bus.dropped  = bus.sample & (state_q != IDLE);
endmodule

// File: tb/tb_coord_ascii_tx.sv
// tb/tb_coord_ascii_tx.sv - randomized self-checking bench for coord_ascii_tx (CR-LF and LF-only builds)
module tb_coord_ascii_tx;
  localparam int M_PLAIN = 0;
  localparam int M_TIMED = 1;
  localparam int M_STALL = 2;
  localparam int M_OVR   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] x_s, y_s;
  logic       sample_s, ready_s;
  bit         rand_rdy;

  int vectors = 0;
  int miscompares = 0;
  int xfer1 = 0, xfer0 = 0, drop1 = 0, drop0 = 0;
  logic [7:0] exp1_q[$];
  logic [7:0] exp0_q[$];

  coord_ascii_tx_if b1();
  coord_ascii_tx_if b0();

  assign b1.x = x_s;  assign b1.y = y_s;  assign b1.sample = sample_s;  assign b1.tx_ready = ready_s;
  assign b0.x = x_s;  assign b0.y = y_s;  assign b0.sample = sample_s;  assign b0.tx_ready = ready_s;

  coord_ascii_tx #(.SEP(8'h2C), .EOL_CR(1'b1)) dut_cr (.clk(clk), .rst_n(rst_n), .bus(b1));
  coord_ascii_tx #(.SEP(8'h2C), .EOL_CR(1'b0)) dut_lf (.clk(clk), .rst_n(rst_n), .bus(b0));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the line is just the signed decimal rendering of both values.
  task automatic push_expected(input logic [7:0] xv, input logic [7:0] yv,
                               output int l1, output int l0);
    string s;
    s = $sformatf("%0d,%0d", $signed(xv), $signed(yv));
    for (int i = 0; i < s.len(); i++) begin
      exp1_q.push_back(s[i]);
      exp0_q.push_back(s[i]);
    end
    exp1_q.push_back(8'h0D);
    exp1_q.push_back(8'h0A);
    exp0_q.push_back(8'h0A);
    l1 = s.len() + 2;
    l0 = s.len() + 1;
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((b1.busy || b0.busy) && i < 300) begin
      @(posedge clk); #1;
      i++;
    end
    check("idle_wait", 32'(b1.busy | b0.busy), 32'h0);
  endtask

  task automatic send(input logic [7:0] xv, input logic [7:0] yv, input int mode);
    int n, n1, n0, stall, d1, d0, l1, l0, base;
    wait_idle();
    d1 = drop1; d0 = drop0; base = xfer1;
    x_s = xv; y_s = yv; sample_s = 1'b1;
    push_expected(xv, yv, l1, l0);
    @(posedge clk); #1;
    sample_s = 1'b0;
    n = 1; n1 = 0; n0 = 0; stall = 0;
    if (mode == M_TIMED) begin
      check("conv_valid_cr", 32'(b1.tx_valid), 32'h0);
      check("conv_busy_cr", 32'(b1.busy), 32'h1);
    end
    while ((n1 == 0 || n0 == 0) && n < 400) begin
      if (mode == M_STALL) begin
        if (xfer1 == base + 2 && stall < 5) begin
          ready_s = 1'b0;
          check("stall_data", 32'(b1.tx_data), 32'h30);
          stall++;
        end else if (stall == 5) begin
          ready_s = 1'b1; rand_rdy = 1'b1; stall++;
        end
      end
      if (mode == M_OVR) begin
        if (n >= 2 && n <= 7) begin
          ready_s = 1'b0;
          sample_s = (n % 2 == 0);
        end else if (n == 8) begin
          sample_s = 1'b0; ready_s = 1'b1; rand_rdy = 1'b1;
        end
      end
      x_s = 8'($urandom);
      y_s = 8'($urandom);
      @(posedge clk); #1;
      n++;
      if (n == 2 && mode == M_TIMED) begin
        check("first_valid_cr", 32'(b1.tx_valid), 32'h1);
        check("first_valid_lf", 32'(b0.tx_valid), 32'h1);
      end
      if (!b1.busy && n1 == 0) n1 = n;
      if (!b0.busy && n0 == 0) n0 = n;
    end
    sample_s = 1'b0;
    if (mode == M_TIMED) begin
      check("busy_len_cr", n1, l1 + 2);
      check("busy_len_lf", n0, l0 + 2);
    end
    check("left_cr", exp1_q.size(), 0);
    check("left_lf", exp0_q.size(), 0);
    check("dropped_cr", drop1 - d1, (mode == M_OVR) ? 3 : 0);
    check("dropped_lf", drop0 - d0, (mode == M_OVR) ? 3 : 0);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (b1.dropped) drop1++;
      if (b0.dropped) drop0++;
      if (b1.tx_valid) begin
        if (exp1_q.size() == 0) check("extra_byte_cr", 32'(b1.tx_data), 32'h100);
        else begin
          check("byte_cr", 32'(b1.tx_data), 32'(exp1_q[0]));
          if (b1.tx_ready) begin void'(exp1_q.pop_front()); xfer1++; end
        end
      end
      if (b0.tx_valid) begin
        if (exp0_q.size() == 0) check("extra_byte_lf", 32'(b0.tx_data), 32'h100);
        else begin
          check("byte_lf", 32'(b0.tx_data), 32'(exp0_q[0]));
          if (b0.tx_ready) begin void'(exp0_q.pop_front()); xfer0++; end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #2;
    if (rand_rdy) ready_s = 1'($urandom_range(0, 1));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i, base;
    int l1, l0;
    rst_n = 1'b0; sample_s = 1'b1; x_s = 8'h12; y_s = 8'h34; ready_s = 1'b1; rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy_cr", 32'(b1.busy), 32'h0);
    check("rst_valid_cr", 32'(b1.tx_valid), 32'h0);
    check("rst_data_cr", 32'(b1.tx_data), 32'h0);
    check("rst_dropped_cr", 32'(b1.dropped), 32'h0);
    check("rst_busy_lf", 32'(b0.busy), 32'h0);
    check("rst_data_lf", 32'(b0.tx_data), 32'h0);
    sample_s = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(b1.busy), 32'h0);

    send(8'hF6, 8'h0C, M_TIMED);
    send(8'hF6, 8'h0C, M_STALL);
    rand_rdy = 1'b0; ready_s = 1'b1;
    send(8'h80, 8'h7F, M_TIMED);
    send(8'h80, 8'h80, M_TIMED);
    send(8'h00, 8'h00, M_TIMED);
    send(8'h9C, 8'h2A, M_OVR);
    rand_rdy = 1'b0; ready_s = 1'b1;
    send(8'h33, 8'hC8, M_TIMED);

    wait_idle();
    base = xfer1;
    x_s = 8'hF6; y_s = 8'h0C; sample_s = 1'b1;
    push_expected(8'hF6, 8'h0C, l1, l0);
    @(posedge clk); #1;
    sample_s = 1'b0;
    i = 0;
    while (xfer1 < base + 3 && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    check("rst_reach", xfer1 - base, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp1_q.delete();
    exp0_q.delete();
    check("mid_rst_valid_cr", 32'(b1.tx_valid), 32'h0);
    check("mid_rst_busy_cr", 32'(b1.busy), 32'h0);
    check("mid_rst_data_cr", 32'(b1.tx_data), 32'h0);
    check("mid_rst_valid_lf", 32'(b0.tx_valid), 32'h0);
    check("mid_rst_data_lf", 32'(b0.tx_data), 32'h0);
    send(8'h05, 8'hFD, M_TIMED);

    rand_rdy = 1'b1;
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      send(8'($urandom), 8'($urandom), M_PLAIN);
    end
    rand_rdy = 1'b0; ready_s = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
